// File: rtl/cache_access_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_controller_pkg
// Purpose  : Shared constants and the controller state encoding.
//            WORD_LENGTH     - data word width
//            DEF_ADDR_W      - default word address width
//            DEF_BLOCK_WORDS - default words per cache block
//            state_t         - controller state encoding
// Revision : 1.0 - initial release
// ============================================================================
package cache_access_controller_pkg;

  localparam int WORD_LENGTH     = 32;
  localparam int DEF_ADDR_W      = 15;
  localparam int DEF_BLOCK_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_FILL    = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_access_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_controller_if
// Purpose  : Bundles the CPU read port, cache port and main-memory port of
//            the cache access controller.
//            master modport - controller side (drives cpu_rdata/cpu_ready/
//                             busy, cache_addr/cache_write/cache_wblock,
//                             mem_rd/mem_addr)
//            slave modport  - CPU, cache and memory side
// Revision : 1.0 - initial release
// ============================================================================
interface cache_access_controller_if
  import cache_access_controller_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = WORD_LENGTH,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) ();

  // CPU read port
  logic                          cpu_req;
  logic [ADDR_W-1:0]             cpu_addr;
  logic [WORD_W-1:0]             cpu_rdata;
  logic                          cpu_ready;
  logic                          busy;
  // Cache port
  logic [ADDR_W-1:0]             cache_addr;
  logic                          cache_hit;
  logic [WORD_W-1:0]             cache_rdata;
  logic                          cache_write;
  logic [BLOCK_WORDS*WORD_W-1:0] cache_wblock;
  // Main-memory port
  logic                          mem_rd;
  logic [ADDR_W-1:0]             mem_addr;
  logic                          mem_valid;
  logic [BLOCK_WORDS*WORD_W-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_addr, cache_hit, cache_rdata, mem_valid, mem_rdata,
    output cpu_rdata, cpu_ready, busy, cache_addr, cache_write, cache_wblock,
           mem_rd, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_hit, cache_rdata, mem_valid, mem_rdata,
    input  cpu_rdata, cpu_ready, busy, cache_addr, cache_write, cache_wblock,
           mem_rd, mem_addr
  );

endinterface
`default_nettype wire

// File: rtl/cache_access_controller_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_controller_line_buffer
// Purpose  : Holds one fetched cache block.
//            clk, rst_n - clock, asynchronous active-low reset
//            load       - capture din this cycle
//            din        - incoming block, word 0 in LSBs
//            offset     - word select within the block
//            block      - stored block (combinational view)
//            word       - stored word selected by offset (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module cache_access_controller_line_buffer
  import cache_access_controller_pkg::*;
#(
  parameter int WORD_W      = WORD_LENGTH,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int OFF_W       = $clog2(DEF_BLOCK_WORDS)
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  input  wire logic                          load,
  input  wire logic [BLOCK_WORDS*WORD_W-1:0] din,
  input  wire logic [OFF_W-1:0]              offset,
  output logic      [BLOCK_WORDS*WORD_W-1:0] block,
  output logic      [WORD_W-1:0]             word
);

  logic [BLOCK_WORDS*WORD_W-1:0] data_q;
  logic [WORD_W-1:0]             words [BLOCK_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end
  end

  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_words
    assign words[i] = data_q[i*WORD_W +: WORD_W];
  end

  assign block = data_q;
  assign word  = words[offset];

endmodule
`default_nettype wire

// File: rtl/cache_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_controller
// Purpose  : Read-path sequencer between the CPU, a direct-mapped cache and
//            main memory. Looks a request up in the cache; on a miss fetches
//            the whole block, writes it into the cache and returns the word.
//            clk, rst_n   - clock, asynchronous active-low reset
//            bus (master) - CPU / cache / memory handshake bundle
//            access_count - LOOKUP cycles seen, saturating (HIT_STATS_EN)
//            hit_count    - LOOKUP cycles that hit, saturating (HIT_STATS_EN)
//            Optional feature macro: HIT_STATS_EN
// Revision : 1.0 - initial release
// ============================================================================
module cache_access_controller
  import cache_access_controller_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = WORD_LENGTH,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  cache_access_controller_if.master  bus
`ifdef HIT_STATS_EN
  ,
  output logic [31:0]                access_count,
  output logic [31:0]                hit_count
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);

  state_t                        state;
  logic [ADDR_W-1:0]             addr_q;
  logic [WORD_W-1:0]             cpu_rdata_q;
  logic                          cpu_ready_q;
  logic                          busy_q;
  logic                          cache_write_q;
  logic                          mem_rd_q;
  logic                          lb_load;
  logic [BLOCK_WORDS*WORD_W-1:0] lb_block;
  logic [WORD_W-1:0]             lb_word;

  // Only a memory response that arrives while fetching is captured.
  assign lb_load = (state == ST_FETCH) && bus.mem_valid;

  cache_access_controller_line_buffer #(
    .WORD_W      (WORD_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .OFF_W       (OFF_W)
  ) u_line_buffer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lb_load),
    .din    (bus.mem_rdata),
    .offset (addr_q[OFF_W-1:0]),
    .block  (lb_block),
    .word   (lb_word)
  );

  // Every strobe is a flop with asynchronous reset, so an interrupted fetch
  // drops mem_rd at once and can never reach the FILL write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      cpu_rdata_q   <= '0;
      cpu_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      cache_write_q <= 1'b0;
      mem_rd_q      <= 1'b0;
    end else begin
      cpu_ready_q   <= 1'b0;
      cache_write_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            addr_q <= bus.cpu_addr;
            busy_q <= 1'b1;
            state  <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (bus.cache_hit) begin
            cpu_rdata_q <= bus.cache_rdata;
            cpu_ready_q <= 1'b1;
            state       <= ST_RESPOND;
          end else begin
            mem_rd_q <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.mem_valid) begin
            mem_rd_q      <= 1'b0;
            cache_write_q <= 1'b1;
            state         <= ST_FILL;
          end
        end
        ST_FILL: begin
          cpu_rdata_q <= lb_word;
          cpu_ready_q <= 1'b1;
          state       <= ST_RESPOND;
        end
        ST_RESPOND: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_rdata    = cpu_rdata_q;
  assign bus.cpu_ready    = cpu_ready_q;
  assign bus.busy         = busy_q;
  assign bus.cache_addr   = addr_q;
  assign bus.cache_write  = cache_write_q;
  assign bus.cache_wblock = lb_block;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.mem_addr     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef HIT_STATS_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_count <= '0;
      hit_count    <= '0;
    end else if (state == ST_LOOKUP) begin
      if (access_count != CNT_MAX) begin
        access_count <= access_count + 32'd1;
      end
      if (bus.cache_hit && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_access_controller
// Purpose  : Directed self-checking bench for cache_access_controller with a
//            small direct-mapped cache model (16 lines) and a memory model.
//            Counter checks are compiled in with HIT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_access_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_access_controller_if bus ();

`ifdef HIT_STATS_EN
  logic [31:0] access_count;
  logic [31:0] hit_count;
`endif

  cache_access_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HIT_STATS_EN
    ,
    .access_count (access_count),
    .hit_count    (hit_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- cache model ----------------
  logic [127:0] c_data  [16];
  logic [8:0]   c_tag   [16];
  logic         c_valid [16];
  logic         cache_clr;
  logic         preload;
  logic [14:0]  pl_addr;
  logic [127:0] pl_data;
  int           wr_count = 0;
  int           ready_cnt = 0;
  int           mem_rd_cycles = 0;
  logic [3:0]   c_idx;

  assign c_idx = bus.cache_addr[5:2];

  always_comb begin
    bus.cache_hit   = c_valid[c_idx] && (c_tag[c_idx] == bus.cache_addr[14:6]);
    bus.cache_rdata = c_data[c_idx][bus.cache_addr[1:0]*32 +: 32];
  end

  always @(posedge clk) begin
    if (cache_clr) begin
      for (int i = 0; i < 16; i++) c_valid[i] <= 1'b0;
    end else if (preload) begin
      c_valid[pl_addr[5:2]] <= 1'b1;
      c_tag[pl_addr[5:2]]   <= pl_addr[14:6];
      c_data[pl_addr[5:2]]  <= pl_data;
    end else if (bus.cache_write) begin
      c_valid[bus.cache_addr[5:2]] <= 1'b1;
      c_tag[bus.cache_addr[5:2]]   <= bus.cache_addr[14:6];
      c_data[bus.cache_addr[5:2]]  <= bus.cache_wblock;
      wr_count <= wr_count + 1;
    end
    if (bus.cpu_ready) ready_cnt <= ready_cnt + 1;
    if (bus.mem_rd) mem_rd_cycles <= mem_rd_cycles + 1;
  end

  // Memory model: word k of a block holds 0xD000_0000 | its own word address.
  function automatic logic [127:0] mem_block(input logic [14:0] a);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[k*32 +: 32] = 32'hD000_0000 | {17'b0, a[14:2], 2'(k)};
    return b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issues one request, serves memory immediately, returns data and latency
  // (ready cycle counted from the IDLE cycle that presents the request).
  task automatic access(input logic [14:0] a, output logic [31:0] d, output int lat, output bit ok);
    ok = 1'b0; lat = 0; d = '0;
    bus.cpu_req = 1'b1; bus.cpu_addr = a;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        ok = 1'b1; lat = i + 1; d = bus.cpu_rdata;
        break;
      end
      bus.mem_valid = bus.mem_rd;
      bus.mem_rdata = mem_block(bus.mem_addr);
    end
    bus.cpu_req = 1'b0; bus.mem_valid = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [127:0] BLK40 = 128'h1111_0003_1111_0002_1111_0001_1111_0000;
  localparam logic [127:0] BLKMS = 128'hBEEF_0003_BEEF_0002_BEEF_0001_BEEF_0000;

  initial begin
    logic [31:0] d;
    int          lat;
    bit          ok;
    int          base, wr0, rc0, n;
    int          rc [3];

    rst_n = 1'b0; cache_clr = 1'b1; preload = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.mem_valid = 1'b0; bus.mem_rdata = '0;
    step(); step();
    // Reset state
    chk("rst_cpu_ready", 128'(bus.cpu_ready), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_mem_rd", 128'(bus.mem_rd), 128'(0));
    chk("rst_cache_write", 128'(bus.cache_write), 128'(0));
    chk("rst_cpu_rdata", 128'(bus.cpu_rdata), 128'(0));
    chk("rst_cache_addr", 128'(bus.cache_addr), 128'(0));
    cache_clr = 1'b0; preload = 1'b1; pl_addr = 15'h0040; pl_data = BLK40;
    step();
    preload = 1'b0; rst_n = 1'b1;
    step();

    // Hit on 0x0041
    base = mem_rd_cycles;
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h0041;
    step();
    chk("hit_lookup_busy", 128'(bus.busy), 128'(1));
    chk("hit_lookup_ready", 128'(bus.cpu_ready), 128'(0));
    chk("hit_cache_addr", 128'(bus.cache_addr), 128'(15'h0041));
    step();
    chk("hit_ready", 128'(bus.cpu_ready), 128'(1));
    chk("hit_rdata", 128'(bus.cpu_rdata), 128'(32'h1111_0001));
    bus.cpu_req = 1'b0;
    step();
    chk("hit_ready_pulse", 128'(bus.cpu_ready), 128'(0));
    chk("hit_idle_busy", 128'(bus.busy), 128'(0));
    chk("hit_no_mem_rd", 128'(mem_rd_cycles), 128'(base));

    // Miss on 0x1236, memory answers in the 4th FETCH cycle
    wr0 = wr_count;
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h1236;
    step();
    step();
    chk("miss_mem_rd", 128'(bus.mem_rd), 128'(1));
    chk("miss_mem_addr", 128'(bus.mem_addr), 128'(15'h1234));
    step();
    chk("miss_mem_rd_held", 128'(bus.mem_rd), 128'(1));
    step();
    chk("miss_no_early_write", 128'(bus.cache_write), 128'(0));
    step();
    bus.mem_valid = 1'b1; bus.mem_rdata = BLKMS;
    step();
    bus.mem_valid = 1'b0; bus.mem_rdata = '0;
    chk("fill_cache_write", 128'(bus.cache_write), 128'(1));
    chk("fill_mem_rd_low", 128'(bus.mem_rd), 128'(0));
    chk("fill_wblock", bus.cache_wblock, BLKMS);
    step();
    chk("miss_ready", 128'(bus.cpu_ready), 128'(1));
    chk("miss_rdata", 128'(bus.cpu_rdata), 128'(32'hBEEF_0002));
    chk("miss_write_pulse", 128'(bus.cache_write), 128'(0));
    chk("miss_one_write", 128'(wr_count), 128'(wr0 + 1));
    bus.cpu_req = 1'b0;
    step();
    base = mem_rd_cycles;
    access(15'h1236, d, lat, ok);
    chk("rehit_ok", 128'(ok), 128'(1));
    chk("rehit_rdata", 128'(d), 128'(32'hBEEF_0002));
    chk("rehit_latency", 128'(lat), 128'(2));
    chk("rehit_no_mem_rd", 128'(mem_rd_cycles), 128'(base));

    // mem_valid in IDLE and LOOKUP must be ignored
    wr0 = wr_count;
    bus.mem_valid = 1'b1; bus.mem_rdata = BLKMS;
    step();
    chk("mv_idle_busy", 128'(bus.busy), 128'(0));
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h2008;
    step();
    chk("mv_lookup_busy", 128'(bus.busy), 128'(1));
    step();
    bus.mem_valid = 1'b0;
    chk("mv_fetch_mem_rd", 128'(bus.mem_rd), 128'(1));
    chk("mv_fetch_no_write", 128'(bus.cache_write), 128'(0));
    step();
    chk("mv_still_fetch", 128'(bus.mem_rd), 128'(1));
    chk("mv_no_write_count", 128'(wr_count), 128'(wr0));
    bus.mem_valid = 1'b1; bus.mem_rdata = mem_block(15'h2008);
    step();
    bus.mem_valid = 1'b0;
    chk("mv_fill", 128'(bus.cache_write), 128'(1));
    step();
    chk("mv_rdata", 128'(bus.cpu_rdata), 128'(32'hD000_2008));
    bus.cpu_req = 1'b0;
    step();

    // Back-to-back hits with cpu_req held
    n = 0; rc[0] = 0; rc[1] = 0; rc[2] = 0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h0041;
    for (int i = 0; i < 30 && n < 3; i++) begin
      step();
      if (bus.cpu_ready) begin rc[n] = i; n++; end
    end
    bus.cpu_req = 1'b0;
    chk("b2b_pulses", 128'(n), 128'(3));
    chk("b2b_first", 128'(rc[0]), 128'(1));
    chk("b2b_gap1", 128'(rc[1] - rc[0]), 128'(3));
    chk("b2b_gap2", 128'(rc[2] - rc[1]), 128'(3));
    step();
    step();

    // Reset during FETCH
    rc0 = ready_cnt; wr0 = wr_count;
    bus.cpu_req = 1'b1; bus.cpu_addr = 15'h3010;
    step();
    step();
    chk("rst_fetch_mem_rd", 128'(bus.mem_rd), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mem_rd", 128'(bus.mem_rd), 128'(0));
    chk("rst_async_busy", 128'(bus.busy), 128'(0));
    chk("rst_async_write", 128'(bus.cache_write), 128'(0));
    bus.cpu_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("rst_no_ready", 128'(ready_cnt), 128'(rc0));
    chk("rst_no_write", 128'(wr_count), 128'(wr0));
    chk("rst_idle", 128'(bus.busy), 128'(0));

    // Five accesses, three hits, two minimum-latency misses
    access(15'h0041, d, lat, ok);
    chk("a1_data", 128'(d), 128'(32'h1111_0001));
    access(15'h1236, d, lat, ok);
    chk("a2_data", 128'(d), 128'(32'hBEEF_0002));
    access(15'h2008, d, lat, ok);
    chk("a3_data", 128'(d), 128'(32'hD000_2008));
    access(15'h3010, d, lat, ok);
    chk("a4_ok", 128'(ok), 128'(1));
    chk("a4_data", 128'(d), 128'(32'hD000_3010));
    chk("a4_min_miss_latency", 128'(lat), 128'(4));
    access(15'h4023, d, lat, ok);
    chk("a5_data", 128'(d), 128'(32'hD000_4023));

`ifdef HIT_STATS_EN
    chk("access_count", 128'(access_count), 128'(5));
    chk("hit_count", 128'(hit_count), 128'(3));
    force dut.access_count = 32'hFFFF_FFFF;
    step();
    release dut.access_count;
    access(15'h0041, d, lat, ok);
    chk("access_count_sat", 128'(access_count), 128'(32'hFFFF_FFFF));
    chk("hit_count_after_sat", 128'(hit_count), 128'(4));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
